// File: rtl/icache_refill_controller_if.sv
// -----------------------------------------------------------------------------
// icache_refill_pkg / icache_refill_controller_if
//
// Purpose : shared types and the signal bundle between the instruction-cache
//           refill controller, the instruction cache and main memory.
//
// Package : icache_refill_pkg
//   cache_wr_control_e : cache external write-port command
//                        (CACHE_NO_WR = idle, CACHE_W_WR = 32-bit word write)
//
// Interface signals (direction as seen by the controller, modport master):
//   miss_in       in   LINE_WORDS  per-word miss flags of the addressed line
//   miss_tag_in   in   TAG_W       tag of the missing line
//   fetch_pc      in   32          PC held at the cache (index + word select)
//   cache_stall   out  1           stall to the cache and the fetch path
//   cache_addr    out  32          cache external write address
//   cache_wr_data out  32          cache external write data
//   cache_wr_en   out  enum        cache write command
//   mem_req       out  1           memory read request
//   mem_addr      out  32          memory word address
//   mem_gnt       in   1           memory accepted the request this cycle
//   mem_rvalid    in   1           mem_rdata valid this cycle
//   mem_rdata     in   32          memory read data
//   busy          out  1           controller is not idle
//
// Modports: master = refill controller, slave = cache / memory side.
// -----------------------------------------------------------------------------

package icache_refill_pkg;

    typedef enum logic {
        CACHE_NO_WR = 1'b0,
        CACHE_W_WR  = 1'b1
    } cache_wr_control_e;

endpackage

interface icache_refill_controller_if #(
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 22
);
    import icache_refill_pkg::*;

    // Cache side
    logic [LINE_WORDS-1:0] miss_in;
    logic [TAG_W-1:0]      miss_tag_in;
    logic [31:0]           fetch_pc;
    logic                  cache_stall;
    logic [31:0]           cache_addr;
    logic [31:0]           cache_wr_data;
    cache_wr_control_e     cache_wr_en;

    // Memory side
    logic                  mem_req;
    logic [31:0]           mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;

    // Status
    logic                  busy;

    modport master (
        input  miss_in, miss_tag_in, fetch_pc,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output cache_stall, cache_addr, cache_wr_data, cache_wr_en,
        output mem_req, mem_addr, busy
    );

    modport slave (
        output miss_in, miss_tag_in, fetch_pc,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  cache_stall, cache_addr, cache_wr_data, cache_wr_en,
        input  mem_req, mem_addr, busy
    );

endinterface

// File: rtl/icache_refill_controller.sv
// -----------------------------------------------------------------------------
// icache_refill_controller
//
// Purpose : instruction-cache miss handler in the fetch stage. When the cache
//           flags missing words it stalls fetch, reads each missing word of
//           the line from memory (req/gnt, then rvalid), writes it into the
//           cache through the external write port and finally releases the
//           stall so the cache looks up the held PC again.
//
// Parameters:
//   LINE_WORDS : words per line (power of 2, >= 2)
//   TAG_W      : cache tag width; index = 32 - TAG_W - log2(LINE_WORDS) - 2
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : icache_refill_controller_if.master (cache + memory signals)
//
// Optional feature (compile-time macro ICACHE_CWF_EN):
//   defined   : critical word first - the walk over the line starts at the
//               word addressed by fetch_pc and wraps around the line.
//   undefined : the walk starts at word 0.
//   Either way exactly LINE_WORDS words are visited (counted by cnt).
// -----------------------------------------------------------------------------

module icache_refill_controller #(
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 22
) (
    input  logic                         clk,
    input  logic                         reset,
    icache_refill_controller_if.master   bus
);
    import icache_refill_pkg::*;

    localparam int PTR_W = $clog2(LINE_WORDS);
    localparam int OFF_W = PTR_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                state;
    logic [31:0]           line_addr;
    logic [LINE_WORDS-1:0] mask;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      cnt;

    logic                  miss_any;
    logic [31:0]           new_line;
    logic [PTR_W-1:0]      start_ptr;
    logic [PTR_W-1:0]      next_ptr;
    logic                  last_word;

    // Line base is aligned, so the word offset can simply be OR-ed in.
    function automatic logic [31:0] word_addr(input logic [31:0]      base,
                                              input logic [PTR_W-1:0] p);
        return base | {{(32-OFF_W){1'b0}}, p, 2'b00};
    endfunction

    assign miss_any  = |bus.miss_in;
    assign new_line  = {bus.miss_tag_in, bus.fetch_pc[31-TAG_W:OFF_W], {OFF_W{1'b0}}};
    assign next_ptr  = ptr + 1'b1;            // wraps modulo LINE_WORDS
    assign last_word = (cnt == PTR_W'(LINE_WORDS - 1));

`ifdef ICACHE_CWF_EN
    assign start_ptr = bus.fetch_pc[OFF_W-1:2];
`else
    assign start_ptr = '0;
`endif

    // Low PC bits only matter for the critical-word start; keep them visibly
    // consumed in both builds.
    logic unused_pc_bits;
    assign unused_pc_bits = ^bus.fetch_pc[OFF_W-1:0];

    // Stall must act in the very cycle the miss shows up, so the IDLE term is
    // combinational; every other state is covered by the registered busy.
    assign bus.cache_stall = !reset && (bus.busy || miss_any);

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            line_addr         <= '0;
            mask              <= '0;
            ptr               <= '0;
            cnt               <= '0;
            bus.busy          <= 1'b0;
            bus.mem_req       <= 1'b0;
            bus.mem_addr      <= '0;
            bus.cache_addr    <= '0;
            bus.cache_wr_data <= '0;
            bus.cache_wr_en   <= CACHE_NO_WR;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.cache_wr_en <= CACHE_NO_WR;
                    if (miss_any) begin
                        line_addr    <= new_line;
                        mask         <= bus.miss_in;
                        ptr          <= start_ptr;
                        cnt          <= '0;
                        bus.busy     <= 1'b1;
                        // Request is raised on REQ entry only for a missing word.
                        bus.mem_req  <= bus.miss_in[start_ptr];
                        bus.mem_addr <= word_addr(new_line, start_ptr);
                        state        <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (!mask[ptr]) begin
                        // Word already valid in the cache: skip without a request.
                        if (last_word) begin
                            bus.mem_req <= 1'b0;
                            state       <= S_DONE;
                        end else begin
                            ptr          <= next_ptr;
                            cnt          <= cnt + 1'b1;
                            bus.mem_req  <= mask[next_ptr];
                            bus.mem_addr <= word_addr(line_addr, next_ptr);
                        end
                    end else if (bus.mem_gnt) begin
                        bus.mem_req <= 1'b0;
                        state       <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (bus.mem_rvalid) begin
                        bus.cache_wr_data <= bus.mem_rdata;
                        bus.cache_addr    <= word_addr(line_addr, ptr);
                        bus.cache_wr_en   <= CACHE_W_WR;
                        state             <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    bus.cache_wr_en <= CACHE_NO_WR;
                    if (last_word) begin
                        state <= S_DONE;
                    end else begin
                        ptr          <= next_ptr;
                        cnt          <= cnt + 1'b1;
                        bus.mem_req  <= mask[next_ptr];
                        bus.mem_addr <= word_addr(line_addr, next_ptr);
                        state        <= S_REQ;
                    end
                end

                S_DONE: begin
                    // One extra stalled cycle, then IDLE re-evaluates miss_in.
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    bus.busy        <= 1'b0;
                    bus.mem_req     <= 1'b0;
                    bus.cache_wr_en <= CACHE_NO_WR;
                    state           <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_controller.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_controller
//
// Directed bench for icache_refill_controller at LINE_WORDS=4, TAG_W=22.
// Inputs change 1 ns after a rising edge; outputs are checked at that point
// (after registered outputs have settled, and after combinational ones have
// reacted to the new inputs).
// -----------------------------------------------------------------------------

module tb_icache_refill_controller;
    import icache_refill_pkg::*;

    logic clk;
    logic reset;

    int checks    = 0;
    int errors    = 0;
    int stall_cnt = 0;

    icache_refill_controller_if #(.LINE_WORDS(4), .TAG_W(22)) bus ();

    icache_refill_controller #(.LINE_WORDS(4), .TAG_W(22)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.cache_stall === 1'b1) stall_cnt++;
    endtask

    // Entered in a REQ cycle that carries a request; leaves in the WRITE cycle.
    task automatic serve(input logic [31:0] addr, input logic [31:0] data,
                         input int gnt_delay, input int rv_delay);
        check("req_high",  32'(bus.mem_req), 32'd1);
        check("req_addr",  bus.mem_addr, addr);
        check("req_no_wr", 32'(bus.cache_wr_en), 32'(CACHE_NO_WR));
        for (int i = 0; i < gnt_delay; i++) begin
            tick();
            check("req_hold",      32'(bus.mem_req), 32'd1);
            check("req_hold_addr", bus.mem_addr, addr);
        end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        check("wait_req_low", 32'(bus.mem_req), 32'd0);
        check("wait_stall",   32'(bus.cache_stall), 32'd1);
        for (int i = 0; i < rv_delay; i++) begin
            tick();
            check("wait_no_wr", 32'(bus.cache_wr_en), 32'(CACHE_NO_WR));
            check("wait_req",   32'(bus.mem_req), 32'd0);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = data;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        check("wr_en",    32'(bus.cache_wr_en), 32'(CACHE_W_WR));
        check("wr_addr",  bus.cache_addr, addr);
        check("wr_data",  bus.cache_wr_data, data);
        check("wr_stall", 32'(bus.cache_stall), 32'd1);
    endtask

    logic [31:0] full_order [4];

    initial begin
`ifdef ICACHE_CWF_EN
        full_order = '{32'h0000_0438, 32'h0000_043C, 32'h0000_0430, 32'h0000_0434};
`else
        full_order = '{32'h0000_0430, 32'h0000_0434, 32'h0000_0438, 32'h0000_043C};
`endif
        reset           = 1'b1;
        bus.miss_in     = '0;
        bus.miss_tag_in = '0;
        bus.fetch_pc    = '0;
        bus.mem_gnt     = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_stall", 32'(bus.cache_stall), 32'd0);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_req",   32'(bus.mem_req), 32'd0);
        check("rst_maddr", bus.mem_addr, 32'd0);
        check("rst_wr_en", 32'(bus.cache_wr_en), 32'(CACHE_NO_WR));
        check("rst_caddr", bus.cache_addr, 32'd0);
        check("rst_wdata", bus.cache_wr_data, 32'd0);
        reset = 1'b0;
        tick();

        // ---- spurious gnt / rvalid while idle ----
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        tick();
        tick();
        check("spur_busy",  32'(bus.busy), 32'd0);
        check("spur_stall", 32'(bus.cache_stall), 32'd0);
        check("spur_wr_en", 32'(bus.cache_wr_en), 32'(CACHE_NO_WR));
        check("spur_req",   32'(bus.mem_req), 32'd0);
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;

        // ---- full-line miss, line 0x430 ----
        bus.miss_in     = 4'b1111;
        bus.miss_tag_in = 22'h1;
        bus.fetch_pc    = 32'h0000_0438;
        #1;
        check("miss_stall_comb", 32'(bus.cache_stall), 32'd1);
        check("miss_busy_idle",  32'(bus.busy), 32'd0);
        stall_cnt = 0;
        tick();
        bus.miss_in  = '0;                 // ignored outside IDLE
        bus.fetch_pc = 32'h0000_0800;      // ignored outside IDLE
        check("full_busy", 32'(bus.busy), 32'd1);
        serve(full_order[0], 32'hA000_0000, 0, 0);
        for (int k = 1; k < 4; k++) begin
            tick();
            serve(full_order[k], 32'hA000_0000 + 32'(k), 0, 0);
        end
        tick();
        check("done_stall", 32'(bus.cache_stall), 32'd1);
        check("done_no_wr", 32'(bus.cache_wr_en), 32'(CACHE_NO_WR));
        check("done_busy",  32'(bus.busy), 32'd1);
        tick();
        check("full_idle_busy",  32'(bus.busy), 32'd0);
        check("full_idle_stall", 32'(bus.cache_stall), 32'd0);
        check("full_stall_cycles", 32'(stall_cnt), 32'd13);

        // ---- partial miss 0101, line 0x430, requested word 0 ----
        bus.miss_in  = 4'b0101;
        bus.fetch_pc = 32'h0000_0430;
        tick();
        bus.miss_in = '0;
        serve(32'h0000_0430, 32'hB000_0000, 0, 0);
        tick();
        check("skip1_req",   32'(bus.mem_req), 32'd0);
        check("skip1_no_wr", 32'(bus.cache_wr_en), 32'(CACHE_NO_WR));
        check("skip1_stall", 32'(bus.cache_stall), 32'd1);
        tick();
        serve(32'h0000_0438, 32'hB000_0002, 0, 0);
        tick();
        check("skip3_req",   32'(bus.mem_req), 32'd0);
        check("skip3_no_wr", 32'(bus.cache_wr_en), 32'(CACHE_NO_WR));
        tick();
        check("part_done_stall", 32'(bus.cache_stall), 32'd1);
        check("part_done_req",   32'(bus.mem_req), 32'd0);
        tick();
        check("part_idle_busy", 32'(bus.busy), 32'd0);

        // ---- grant delayed 3 cycles, rvalid delayed 2; miss persists ----
        bus.miss_in  = 4'b0001;
        bus.fetch_pc = 32'h0000_0430;
        tick();
        serve(32'h0000_0430, 32'hC0DE_0001, 3, 2);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("dly_one_write", 32'(bus.cache_wr_en), 32'(CACHE_NO_WR));
            check("dly_skip_req",  32'(bus.mem_req), 32'd0);
        end
        tick();
        check("dly_done_busy", 32'(bus.busy), 32'd1);
        tick();
        // miss_in still set: stall comes straight back in IDLE
        check("persist_idle_busy",  32'(bus.busy), 32'd0);
        check("persist_idle_stall", 32'(bus.cache_stall), 32'd1);
        tick();
        check("persist_restart_busy", 32'(bus.busy), 32'd1);
        check("persist_restart_req",  32'(bus.mem_req), 32'd1);
        check("persist_restart_addr", bus.mem_addr, 32'h0000_0430);

        // ---- reset while in WAIT ----
        bus.miss_in = '0;
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        check("pre_rst_wait_req", 32'(bus.mem_req), 32'd0);
        check("pre_rst_busy",     32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("async_rst_busy",  32'(bus.busy), 32'd0);
        check("async_rst_stall", 32'(bus.cache_stall), 32'd0);
        tick();
        reset = 1'b0;
        check("rst_wait_req",   32'(bus.mem_req), 32'd0);
        check("rst_wait_stall", 32'(bus.cache_stall), 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h5555_AAAA;
        tick();
        bus.mem_rvalid = 1'b0;
        check("late_rv_no_wr", 32'(bus.cache_wr_en), 32'(CACHE_NO_WR));
        check("late_rv_busy",  32'(bus.busy), 32'd0);
        tick();
        check("late_rv_no_wr2", 32'(bus.cache_wr_en), 32'(CACHE_NO_WR));
        check("late_rv_stall",  32'(bus.cache_stall), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_refill_controller.md
Name: icache_refill_controller

Overview:
- Miss handler for the instruction cache inside the instruction fetch stage.
- Detects an instruction cache miss and stalls fetch while it runs.
- Fetches the missing words of the line from main memory over a request/grant/valid interface.
- Writes each word into the cache through the cache's external write port, then releases the stall so the cache re-looks-up the held PC.

Parameters:
LINE_WORDS, 4, words per cache line; power of 2, at least 2; line offset bits = log2(LINE_WORDS)+2
TAG_W, 22, cache tag width; index bits = 32 - TAG_W - offset bits (6 at defaults)

Ports:
clk  in  1  clock; all flops on rising edge
reset  in  1  asynchronous, active-high reset
miss_in  in  LINE_WORDS  per-word miss flags from the instruction cache; bit i set = word i of the addressed line is invalid
miss_tag_in  in  TAG_W  tag of the missing line, from the cache
fetch_pc  in  32  PC presented to the cache; supplies the index and the requested word
cache_stall  out  1  to the cache stall input and the fetch stall path
cache_addr  out  32  cache external write address
cache_wr_data  out  32  cache external write data
cache_wr_en  out  CacheWrControl  CACHE_NO_WR, or CACHE_W_WR for a word write
mem_req  out  1  memory read request
mem_addr  out  32  memory word address
mem_gnt  in  1  memory accepted the request this cycle
mem_rvalid  in  1  mem_rdata is valid this cycle
mem_rdata  in  32  read data
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset state: IDLE.
- Reset values: every output 0 and cache_wr_en = CACHE_NO_WR; internal pointer, counter and mask are 0.
- IDLE:
  - cache_stall = |miss_in, combinational, so the PC holds in the same cycle the miss appears.
  - On |miss_in:
    - latch line_addr = {miss_tag_in, fetch_pc[31-TAG_W:offset], offset zeros};
    - latch mask = miss_in;
    - ptr = 0; cnt = 0;
    - go to REQ.
- REQ:
  - If mask[ptr] = 0, skip the word: no request; if cnt = LINE_WORDS-1 go to DONE, else ptr+1, cnt+1, stay in REQ.
  - Otherwise drive mem_req = 1 and mem_addr = line_addr + 4*ptr.
  - mem_req and mem_addr stay stable until mem_gnt is sampled high; then go to WAIT.
- WAIT:
  - mem_req = 0.
  - Wait any number of cycles for mem_rvalid; on mem_rvalid, capture mem_rdata and go to WRITE.
- WRITE (one cycle):
  - cache_wr_en = CACHE_W_WR, cache_addr = line_addr + 4*ptr, cache_wr_data = captured word.
  - If cnt = LINE_WORDS-1 go to DONE; else ptr+1, cnt+1, go to REQ.
- DONE (one cycle): cache_stall = 1, no write; then IDLE, where miss_in is re-evaluated. A persisting miss starts a new refill.
- cache_stall: 1 in REQ, WAIT, WRITE and DONE.
- ptr arithmetic: modulo LINE_WORDS (wraps); cnt counts visited words, independent of ptr.
- At most one memory transaction is outstanding.
- Ignored inputs:
  - mem_gnt outside REQ-with-request;
  - mem_rvalid outside WAIT;
  - miss_in and fetch_pc changes outside IDLE (the latched line is used).
- A branch or flush during a refill does not abort it; the line always completes.
- Reset mid-refill: immediate return to IDLE, all outputs 0. Words already written remain valid. A late mem_rvalid after reset is ignored.
- Latency, full-line miss, gnt same cycle as req, rvalid next cycle: 3 cycles per word plus DONE. At defaults, 13 cycles of stall after the miss cycle.

Optional Feature:
ICACHE_CWF_EN (critical word first):
- Defined: on entering REQ, ptr = fetch_pc[offset-1:2] instead of 0. Words are visited from the critical word upward, wrapping modulo LINE_WORDS. Termination still uses cnt.
- Undefined: words are visited 0 to LINE_WORDS-1.

Test Plan:
- Full miss, no macro: miss_in=4'b1111, miss_tag_in=22'h1, fetch_pc=0x438, gnt same cycle, rvalid next cycle -> mem_addr 0x430, 0x434, 0x438, 0x43C; matching CACHE_W_WR writes with returned data; cache_stall high for 13 cycles after the miss cycle; then busy=0.
- Same stimulus with ICACHE_CWF_EN -> request and write order 0x438, 0x43C, 0x430, 0x434.
- Partial miss: miss_in=4'b0101, line 0x430 -> only 0x430 and 0x438 requested and written; skipped words produce no mem_req.
- Grant delayed 3 cycles -> mem_req high and mem_addr=0x430 stable for 4 cycles; exactly one WRITE follows rvalid.
- reset pulsed while in WAIT -> next cycle state IDLE, cache_stall=0, mem_req=0; a later mem_rvalid produces no cache write.
- Spurious mem_rvalid/mem_gnt in IDLE with miss_in=0 -> no state change, cache_wr_en stays CACHE_NO_WR, cache_stall=0.
